// File: rtl/video_vga_dbl_ctrl_if.sv
// Scan-doubler scheduler bus: TV/VGA timing pulses in, line buffer controls out.
interface video_vga_dbl_ctrl_if #(
    parameter int unsigned ADDR_W = 9
);
    logic              hsync_start;
    logic              wr_pix_stb;
    logic              scanout_start;
    logic              rd_pix_stb;
    logic              buf_wr_en;
    logic [ADDR_W:0]   buf_wr_addr;
    logic              buf_rd_en;
    logic [ADDR_W:0]   buf_rd_addr;
    logic              rd_blank;
    logic              line_rep;
    logic              scan_active;
    logic              err_collide;
    logic              err_restart;

    // Timing source / buffer consumer side
    modport master (
        output hsync_start, wr_pix_stb, scanout_start, rd_pix_stb,
        input  buf_wr_en, buf_wr_addr, buf_rd_en, buf_rd_addr, rd_blank,
        input  line_rep, scan_active, err_collide, err_restart
    );

    // Scheduler side
    modport slave (
        input  hsync_start, wr_pix_stb, scanout_start, rd_pix_stb,
        output buf_wr_en, buf_wr_addr, buf_rd_en, buf_rd_addr, rd_blank,
        output line_rep, scan_active, err_collide, err_restart
    );
endinterface

// File: rtl/video_vga_dbl_ctrl.sv
// VGA scan-doubler line buffer scheduler: ping-pong write bank per TV line,
// the completed bank is read out once per VGA line (twice per TV line).
// Optional macro VGA_DBL_BLANK_EN: per-bank written counts drive rd_blank.
module video_vga_dbl_ctrl #(
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned LINE_PIX = 360
) (
    input logic clk,
    input logic rst,
    video_vga_dbl_ctrl_if.slave bus
);
    localparam int unsigned IDX_W = ADDR_W + 1;
    localparam logic [IDX_W-1:0] LINE_END = IDX_W'(LINE_PIX);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_PIX - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t             state;
    logic               wr_bank;
    logic [IDX_W-1:0]   wr_idx;
    logic               rd_bank;
    logic [IDX_W-1:0]   rd_idx;
    logic               wr_en_q;
    logic [IDX_W-1:0]   wr_addr_q;
    logic               rd_en_q;
    logic [IDX_W-1:0]   rd_addr_q;
    logic               blank_q;
    logic               line_rep_q;
    logic               scan_q;
    logic               collide_q;
    logic               restart_q;

    // Write side: bank toggles per TV line, index saturates at LINE_PIX
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank   <= 1'b0;
            wr_idx    <= LINE_END;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (bus.hsync_start) begin
                wr_bank <= ~wr_bank;
                if (bus.wr_pix_stb) begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= {~wr_bank, ADDR_W'(0)};
                    wr_idx    <= IDX_W'(1);
                end else begin
                    wr_idx <= '0;
                end
            end else if (bus.wr_pix_stb && (wr_idx < LINE_END)) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= {wr_bank, wr_idx[ADDR_W-1:0]};
                wr_idx    <= wr_idx + IDX_W'(1);
            end
        end
    end

`ifdef VGA_DBL_BLANK_EN
    logic [IDX_W-1:0] wr_cnt [2];

    // Capture how far the retiring bank was written
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt[0] <= '0;
            wr_cnt[1] <= '0;
        end else if (bus.hsync_start) begin
            wr_cnt[wr_bank] <= wr_idx;
        end
    end
`endif

    // Read FSM: scan the completed bank, track repeat and error conditions
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rd_bank    <= 1'b0;
            rd_idx     <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            blank_q    <= 1'b0;
            line_rep_q <= 1'b0;
            scan_q     <= 1'b0;
            collide_q  <= 1'b0;
            restart_q  <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            blank_q <= 1'b0;
            if (bus.scanout_start) begin
                state   <= SCAN;
                scan_q  <= 1'b1;
                rd_idx  <= '0;
                rd_bank <= bus.hsync_start ? wr_bank : ~wr_bank;
                if (state == SCAN) begin
                    restart_q <= 1'b1;
                end
            end else if ((state == SCAN) && bus.rd_pix_stb) begin
                rd_en_q   <= 1'b1;
                rd_addr_q <= {rd_bank, rd_idx[ADDR_W-1:0]};
`ifdef VGA_DBL_BLANK_EN
                blank_q   <= (rd_idx >= wr_cnt[rd_bank]);
`endif
                rd_idx    <= rd_idx + IDX_W'(1);
                if (rd_idx == LAST_IDX) begin
                    state      <= IDLE;
                    scan_q     <= 1'b0;
                    line_rep_q <= 1'b1;
                end
            end
            // A new TV line always starts at its first VGA copy
            if (bus.hsync_start) begin
                line_rep_q <= 1'b0;
            end
            // New write bank lands on the bank still being scanned
            if (bus.hsync_start && !bus.scanout_start && (state == SCAN)
                && (~wr_bank == rd_bank)) begin
                collide_q <= 1'b1;
            end
        end
    end

    assign bus.buf_wr_en   = wr_en_q;
    assign bus.buf_wr_addr = wr_addr_q;
    assign bus.buf_rd_en   = rd_en_q;
    assign bus.buf_rd_addr = rd_addr_q;
    assign bus.rd_blank    = blank_q;
    assign bus.line_rep    = line_rep_q;
    assign bus.scan_active = scan_q;
    assign bus.err_collide = collide_q;
    assign bus.err_restart = restart_q;
endmodule
